tile_pixel_renderer: RTL and testbench

//  Pipelined per-pixel colour generator for one maze tile; successor to the fixed single-colour food box.

---
 rtl/pacman_definitions.sv | 29 ++
 rtl/blink_timer.sv | 35 +++
 rtl/tile_pixel_renderer.sv | 116 +++++++++++
 tb/tb_tile_pixel_renderer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pacman_definitions.sv
// Shared maze constants: tile geometry, tile codes and palette.
// Imported by the tile renderer and its blink timer.
package pacman_definitions;

  localparam int PIXELS_WIDTH     = 16;
  localparam int REL_BITS         = 4;
  localparam int PIXEL_COLOR_BITS = 8;

  typedef enum logic [1:0] {
    TILE_EMPTY  = 2'd0,
    TILE_WALL   = 2'd1,
    TILE_FOOD   = 2'd2,
    TILE_PELLET = 2'd3
  } tile_e;

  localparam logic [7:0] COLOR_BG     = 8'h00;
  localparam logic [7:0] COLOR_WALL   = 8'h03;
  localparam logic [7:0] COLOR_FOOD   = 8'h07;
  localparam logic [7:0] COLOR_PELLET = 8'hFF;

  typedef struct packed {
    tile_e kind;
    logic  border;
    logic  food;
    logic  pel;
    logic  phase;
  } s1_t;

endpackage

// File: rtl/blink_timer.sv
// Power-pellet blink timer: phase toggles every BLINK_FRAMES frame ticks.
// Phase resets to 1 so pellets are visible right after reset.
module blink_timer
  import pacman_definitions::*;
#(
  parameter int BLINK_FRAMES = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_tick,
  output logic phase
);

  localparam int CW =
    (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(BLINK_FRAMES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (frame_tick) begin
      if (cnt == LAST) begin
        cnt   <= '0;
        phase <= ~phase;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tile_pixel_renderer.sv
// Two-stage per-pixel colour generator for one maze tile.
// Stage 1 classifies the pixel, stage 2 picks the colour.
module tile_pixel_renderer
  import pacman_definitions::*;
#(
  parameter int PIXELS_WIDTH     = pacman_definitions::PIXELS_WIDTH,
  parameter int REL_BITS         = pacman_definitions::REL_BITS,
  parameter int PIXEL_COLOR_BITS = pacman_definitions::PIXEL_COLOR_BITS,
  parameter int FOOD_RADIUS      = 1,
  parameter int PELLET_RADIUS    = 3,
  parameter int BLINK_FRAMES     = 15,
  parameter logic [PIXEL_COLOR_BITS-1:0] COLOR_BG =
    PIXEL_COLOR_BITS'(pacman_definitions::COLOR_BG),
  parameter logic [PIXEL_COLOR_BITS-1:0] COLOR_WALL =
    PIXEL_COLOR_BITS'(pacman_definitions::COLOR_WALL),
  parameter logic [PIXEL_COLOR_BITS-1:0] COLOR_FOOD =
    PIXEL_COLOR_BITS'(pacman_definitions::COLOR_FOOD),
  parameter logic [PIXEL_COLOR_BITS-1:0] COLOR_PELLET =
    PIXEL_COLOR_BITS'(pacman_definitions::COLOR_PELLET)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        frame_tick,
  input  logic                        in_valid,
  input  logic [1:0]                  tile_type,
  input  logic [REL_BITS-1:0]         x,
  input  logic [REL_BITS-1:0]         y,
  output logic                        out_valid,
  output logic [PIXEL_COLOR_BITS-1:0] pixels,
  output logic                        blink_phase
);

  localparam int RW   = REL_BITS + 1;
  localparam int HALF = PIXELS_WIDTH / 2;

  // One extra bit so window bounds never wrap.
  localparam logic [RW-1:0] EDGE_HI = RW'(PIXELS_WIDTH - 1);
  localparam logic [RW-1:0] FOOD_LO = RW'(HALF - FOOD_RADIUS);
  localparam logic [RW-1:0] FOOD_HI = RW'(HALF + FOOD_RADIUS - 1);
  localparam logic [RW-1:0] PEL_LO  = RW'(HALF - PELLET_RADIUS);
  localparam logic [RW-1:0] PEL_HI  = RW'(HALF + PELLET_RADIUS - 1);

  function automatic logic in_win(
    input logic [RW-1:0] v,
    input logic [RW-1:0] lo,
    input logic [RW-1:0] hi
  );
    return (v >= lo) && (v <= hi);
  endfunction

  logic [RW-1:0] xe;
  logic [RW-1:0] ye;
  s1_t           s1_next;
  s1_t           s1;
  logic          s1_valid;
  logic [PIXEL_COLOR_BITS-1:0] color;

  assign xe = {1'b0, x};
  assign ye = {1'b0, y};

  blink_timer #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink (
    .clk       (clk),
    .rst_n     (rst_n),
    .frame_tick(frame_tick),
    .phase     (blink_phase)
  );

  always_comb begin
    s1_next        = '0;
    s1_next.kind   = tile_e'(tile_type);
    s1_next.border = (xe == '0) || (xe == EDGE_HI) ||
                     (ye == '0) || (ye == EDGE_HI);
    s1_next.food   = in_win(xe, FOOD_LO, FOOD_HI) &&
                     in_win(ye, FOOD_LO, FOOD_HI);
    s1_next.pel    = in_win(xe, PEL_LO, PEL_HI) &&
                     in_win(ye, PEL_LO, PEL_HI);
    s1_next.phase  = blink_phase;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else begin
      s1_valid <= in_valid;
      s1       <= s1_next;
    end
  end

  always_comb begin
    color = COLOR_BG;
    unique case (s1.kind)
      TILE_EMPTY:  color = COLOR_BG;
      TILE_WALL:   color = s1.border ? COLOR_WALL : COLOR_BG;
      TILE_FOOD:   color = s1.food ? COLOR_FOOD : COLOR_BG;
      TILE_PELLET: color = (s1.pel && s1.phase) ?
                           COLOR_PELLET : COLOR_BG;
      default:     color = COLOR_BG;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      pixels    <= '0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        pixels <= color;
      end
    end
  end

endmodule

// File: tb/tb_tile_pixel_renderer.sv
// Scoreboard bench for tile_pixel_renderer against a tile-drawing model.
// Requests push expected colour and due cycle; a monitor pops on out_valid.
module tb_tile_pixel_renderer;

  localparam int W  = 16;
  localparam int FR = 1;
  localparam int PR = 3;
  localparam int BF = 15;

  logic       clk;
  logic       rst_n;
  logic       frame_tick;
  logic       in_valid;
  logic [1:0] tile_type;
  logic [3:0] x;
  logic [3:0] y;
  logic       out_valid;
  logic [7:0] pixels;
  logic       blink_phase;

  typedef struct {
    logic [7:0] px;
    int         due;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   n_hits = 0;
  bit   m_phase = 1'b1;
  int   m_cnt   = 0;

  tile_pixel_renderer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .in_valid   (in_valid),
    .tile_type  (tile_type),
    .x          (x),
    .y          (y),
    .out_valid  (out_valid),
    .pixels     (pixels),
    .blink_phase(blink_phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic bit in_win(input int v, input int r);
    return v >= W/2 - r && v <= W/2 + r - 1;
  endfunction

  function automatic logic [7:0] model(input int t, input int px,
                                       input int py, input bit ph);
    case (t)
      1: return (px == 0 || px == W-1 || py == 0 || py == W-1)
                ? 8'h03 : 8'h00;
      2: return (in_win(px, FR) && in_win(py, FR)) ? 8'h07 : 8'h00;
      3: return (in_win(px, PR) && in_win(py, PR) && ph)
                ? 8'hFF : 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  task automatic step(input bit v, input int t, input int px,
                      input int py, input bit tk);
    exp_t e;
    @(negedge clk);
    in_valid   = v;
    tile_type  = 2'(t);
    x          = 4'(px);
    y          = 4'(py);
    frame_tick = tk;
    if (v) begin
      e.px  = model(t, px, py, m_phase);
      e.due = cyc + 2;
      sb.push_back(e);
    end
    if (tk) begin
      if (m_cnt == BF - 1) begin
        m_cnt   = 0;
        m_phase = !m_phase;
      end else begin
        m_cnt++;
      end
    end
    @(posedge clk);
    #1;
    chk("blink_phase", int'(blink_phase), int'(m_phase));
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid   = 1'b0;
    frame_tick = 1'b0;
    while (sb.size() != 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain_empty", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      chk("reset_out_valid", int'(out_valid), 0);
      chk("reset_pixels", int'(pixels), 0);
    end else if (out_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_out_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("pixels", int'(pixels), int'(e.px));
        chk("latency_cycle", cyc, e.due);
        if (pixels != 8'h00) n_hits++;
      end
    end else if (sb.size() != 0 && sb[0].due <= cyc) begin
      chk("missing_out_valid", 0, 1);
      void'(sb.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    frame_tick = 1'b0;
    tile_type  = 2'd0;
    x          = 4'd0;
    y          = 4'd0;
    repeat (3) @(negedge clk);
    chk("reset_blink_phase", int'(blink_phase), 1);
    rst_n = 1'b1;

    step(1, 2, 8, 8, 0);
    drain();

    n_hits = 0;
    for (int i = 0; i < 256; i++) step(1, 2, i % 16, i / 16, 0);
    drain();
    chk("food_hit_count", n_hits, 4);

    n_hits = 0;
    for (int i = 0; i < 256; i++) step(1, 1, i / 16, i % 16, 0);
    drain();
    chk("wall_hit_count", n_hits, 60);

    for (int i = 0; i < 18; i++) step(1, 3, 5, 10, i < 15);
    drain();
    chk("phase_after_15_ticks", int'(blink_phase), 0);

    step(1, 0, 3, 4, 0);
    step(0, 0, 3, 4, 0);
    step(1, 0, 9, 1, 0);
    step(1, 0, 15, 15, 0);
    drain();

    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3),
           $urandom_range(0, 15), $urandom_range(0, 15),
           $urandom_range(0, 2) == 0);
    drain();

    step(1, 3, 6, 6, 1);
    step(1, 2, 7, 7, 0);
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    frame_tick = 1'b0;
    sb.delete();
    m_phase = 1'b1;
    m_cnt   = 0;
    #1;
    chk("reset_drop_out_valid", int'(out_valid), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0);
    chk("post_reset_phase", int'(blink_phase), 1);
    for (int i = 0; i < 14; i++) step(1, 3, 5, 5, 1);
    chk("cnt_restart_phase", int'(blink_phase), 1);
    step(1, 3, 5, 5, 1);
    step(1, 3, 5, 5, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
